uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised, synthesizable serial receiver with an integrated receive FIFO. Successor to the fixed-format terminal serial models used on the board-level bench. It oversamples IN_SERIAL_RX, majority-votes each bit, decodes configurable-width frames with optional parity, and queues words in a first-word-fall-through FIFO with a valid/ready read port. It sits between the board RX pin and any command decoder in the ProjectPon_VCentury top level.

## Interface
- CLK_HZ, 25_000_000, system clock frequency
- BAUD, 9600, line rate
- OVERSAMPLE, 16, ticks per bit, even, ≥8
- DATA_BITS, 8, data bits per frame, 5–9
- FIFO_DEPTH, 16, FIFO entries, power of two ≥2
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; used only with parity compiled in

- CLK  in  1  system clock, rising edge
- RESET  in  1  synchronous, active-high reset
- IN_SERIAL_RX  in  1  asynchronous serial line, idle high
- OUT_DATA  out  DATA_BITS  FIFO head word, LSB = first received bit
- OUT_VALID  out  1  FIFO non-empty
- IN_READY  in  1  consumer accepts the head word when OUT_VALID=1
- OUT_COUNT  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- OUT_FRAME_ERR  out  1  one-cycle pulse: stop bit sampled low
- OUT_PARITY_ERR  out  1  one-cycle pulse: parity mismatch
- OUT_OVERRUN  out  1  one-cycle pulse: word dropped because the FIFO was full

## Operation
- Input: 2-FF synchronizer, both stages reset to 1.
- Tick generator: DIV = round(CLK_HZ/(BAUD·OVERSAMPLE)). A one-cycle tick fires every DIV cycles, free-running. With the defaults, DIV=163 and one bit = 2608 cycles.
- Bit sampling: samples are taken at tick indices OVERSAMPLE/2−1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within the bit. The 2-of-3 majority is decided at index OVERSAMPLE/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: on a synchronized 0, go to START and clear the tick index.
  - START: if the vote is 1, it is a glitch; go to IDLE with no error. If the vote is 0, go to DATA.
  - DATA: shift in DATA_BITS votes, LSB first. Then go to PARITY if parity is compiled in, otherwise to STOP.
  - PARITY: compare the vote against the computed parity of the data bits and latch a mismatch flag. Go to STOP.
  - STOP: if the vote is 1, push the word, or discard it if parity mismatched. Pulse OUT_PARITY_ERR on a mismatch. Go to IDLE.
  - STOP with a vote of 0: pulse OUT_FRAME_ERR, discard the word, go to BREAK.
  - BREAK: stay until the synchronized line is 1, then go to IDLE.
- FIFO (first-word-fall-through):
  - OUT_DATA always shows the head word.
  - OUT_VALID = (OUT_COUNT≠0).
  - Pop when OUT_VALID & IN_READY.
  - Pointers wrap modulo FIFO_DEPTH.
- Push and pop in the same cycle: count is unchanged. This holds when the FIFO is full, so a pop frees the slot for a simultaneous push and no overrun occurs.
- Push when full with no pop: the new word is dropped, OUT_OVERRUN pulses, and FIFO contents are unchanged.
- Empty FIFO with push: no pop is possible in that cycle, because OUT_VALID=0.
- Error pulses are mutually exclusive per frame. A push does not depend on IN_READY.

## Timing
- Reset values: OUT_DATA=0, OUT_VALID=0, OUT_COUNT=0, all error pulses 0, FSM in IDLE, tick counter 0, FIFO pointers 0.
- RESET asserted mid-frame: the partial word is discarded. The FIFO is cleared on the next edge.
- The push is registered one cycle after the STOP decision tick. OUT_VALID and OUT_COUNT update on that same edge.
- OUT_DATA is valid in the same cycle OUT_VALID rises.
- Error pulses are high for exactly one cycle, aligned with the cycle a push would have occurred.
- Pop latency: the next head word appears on OUT_DATA on the edge after the accepted handshake.
- Start-edge detect latency: 2 cycles (synchronizer) plus up to DIV cycles of tick phase.

## Configuration
- UART_RX_PARITY_EN defined: the PARITY state exists, frames carry one parity bit after the data, and OUT_PARITY_ERR is functional.
- UART_RX_PARITY_EN undefined: the frame is start + DATA_BITS + stop, the PARITY state is not generated, PARITY_ODD is ignored, and OUT_PARITY_ERR is tied to 0.

## Test plan
- Defaults, parity off; send 0x55 then 0xA3 at 9600 baud → FIFO holds 0x55, 0xA3; OUT_COUNT=2; no error pulses.
- Send 0x3C with the stop bit forced low, then the line held low for 3 bit times → one OUT_FRAME_ERR pulse, no push, FSM stays in BREAK until the line returns high; next frame 0x11 is received correctly.
- With UART_RX_PARITY_EN and PARITY_ODD=0, send 0x07 with parity bit 0 → OUT_PARITY_ERR pulses and OUT_COUNT stays 0; resend with parity bit 1 → 0x07 is pushed.
- IN_READY=0, send 17 words 0x00..0x10 with FIFO_DEPTH=16 → OUT_COUNT=16 and one OUT_OVERRUN pulse; draining yields 0x00..0x0F in order.
- With the FIFO full, assert IN_READY for one cycle exactly on the push cycle of a 17th word → no overrun, count stays 16, and the new word lands at the tail.
- 1-tick low glitch on the idle line → FSM returns to IDLE with no push and no error; separately, assert RESET mid-data-bit → OUT_COUNT=0 and OUT_VALID=0 on the next cycle, and the following frame is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Oversampling serial receiver with majority-vote bit decisions and a first-word-fall-through receive FIFO.
// Optional parity checking is compiled in with the UART_RX_PARITY_EN macro.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 25_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          IN_SERIAL_RX,
  output logic [DATA_BITS-1:0]          OUT_DATA,
  output logic                          OUT_VALID,
  input  logic                          IN_READY,
  output logic [$clog2(FIFO_DEPTH):0]   OUT_COUNT,
  output logic                          OUT_FRAME_ERR,
  output logic                          OUT_PARITY_ERR,
  output logic                          OUT_OVERRUN
);

  localparam int DIV   = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = $clog2(OVERSAMPLE);
  localparam int BC_W  = $clog2(DATA_BITS);
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

`ifdef UART_RX_PARITY_EN
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction
`endif

  state_t                 state, state_nxt;
  logic                   rx_sync_p0, rx_sync_p1;
  logic [DIV_W-1:0]       div_cnt;
  logic                   tick;
  logic [IDX_W-1:0]       idx;
  logic [1:0]             smp;
  logic                   dec, vote;
  logic [BC_W-1:0]        bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   vld_nxt, ferr_nxt, perr_nxt;
  logic                   vld_p1, ferr_p1, perr_p1;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad;
`endif

  // Stage p0/p1: two-flop synchronizer, idles high
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_sync_p0 <= IN_SERIAL_RX;
      rx_sync_p1 <= rx_sync_p0;
    end
  end

  assign tick = (div_cnt == DIV_W'(DIV - 1));
  assign dec  = tick && (idx == IDX_W'(OVERSAMPLE / 2 + 1));
  assign vote = maj3(smp[0], smp[1], rx_sync_p1);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_cnt <= '0;
      idx     <= '0;
      bit_cnt <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      // The tick index is re-phased to each start edge so the vote lands mid-bit.
      if (state == IDLE && !rx_sync_p1)
        idx <= '0;
      else if (tick)
        idx <= (idx == IDX_W'(OVERSAMPLE - 1)) ? '0 : idx + IDX_W'(1);
      if (state == START)
        bit_cnt <= '0;
      else if (state == DATA && dec)
        bit_cnt <= bit_cnt + BC_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (tick && idx == IDX_W'(OVERSAMPLE / 2 - 1))
      smp[0] <= rx_sync_p1;
    if (tick && idx == IDX_W'(OVERSAMPLE / 2))
      smp[1] <= rx_sync_p1;
    if (state == DATA && dec)
      shreg <= {vote, shreg[DATA_BITS-1:1]};
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge CLK) begin
    if (RESET)
      par_bad <= 1'b0;
    else if (state == START)
      par_bad <= 1'b0;
    else if (state == PARITY && dec)
      par_bad <= (vote != calc_parity(shreg, PARITY_ODD));
  end
`endif

  always_ff @(posedge CLK) begin
    if (RESET)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    vld_nxt   = 1'b0;
    ferr_nxt  = 1'b0;
    perr_nxt  = 1'b0;
    case (state)
      IDLE:  if (!rx_sync_p1) state_nxt = START;
      START: if (dec) state_nxt = vote ? IDLE : DATA;
      DATA: begin
        if (dec && bit_cnt == BC_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (dec) state_nxt = STOP;
`endif
      STOP: begin
        if (dec) begin
          if (vote) begin
            state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
            perr_nxt  = par_bad;
            vld_nxt   = !par_bad;
`else
            vld_nxt   = 1'b1;
`endif
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK:   if (rx_sync_p1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: push request and error pulses share one registered cycle
  always_ff @(posedge CLK) begin
    if (RESET) begin
      vld_p1  <= 1'b0;
      ferr_p1 <= 1'b0;
      perr_p1 <= 1'b0;
    end else begin
      vld_p1  <= vld_nxt;
      ferr_p1 <= ferr_nxt;
      perr_p1 <= perr_nxt;
    end
  end

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 full, pop, push;

  assign full = (count == (AW + 1)'(FIFO_DEPTH));
  assign pop  = OUT_VALID & IN_READY;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign push = vld_p1 & (!full | pop);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count <= count + (AW + 1)'(1);
      else if (pop && !push)
        count <= count - (AW + 1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push)
      mem[wr_ptr] <= shreg;
  end

  assign OUT_COUNT     = count;
  assign OUT_VALID     = (count != '0);
  assign OUT_DATA      = OUT_VALID ? mem[rd_ptr] : '0;
  assign OUT_FRAME_ERR = ferr_p1;
  assign OUT_OVERRUN   = vld_p1 & full & !pop;
`ifdef UART_RX_PARITY_EN
  assign OUT_PARITY_ERR = perr_p1;
`else
  assign OUT_PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed/randomized bench for uart_rx_fifo: serial frames are driven bit by bit and the
// received words and error pulses are compared with a queue-based frame model.
module tb_uart_rx_fifo;
  localparam int CLK_HZ  = 1_000_000;
  localparam int BAUD    = 40_000;
  localparam int OS      = 8;
  localparam int DB      = 8;
  localparam int DEPTH   = 16;
  localparam bit PODD    = 1'b0;
  localparam int DIV     = (2 * CLK_HZ + BAUD * OS) / (2 * BAUD * OS);
  localparam int BIT_CYC = DIV * OS;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic                     CLK = 1'b0;
  logic                     RESET, IN_SERIAL_RX, IN_READY;
  logic [DB-1:0]            OUT_DATA;
  logic                     OUT_VALID;
  logic [$clog2(DEPTH):0]   OUT_COUNT;
  logic                     OUT_FRAME_ERR, OUT_PARITY_ERR, OUT_OVERRUN;

  uart_rx_fifo #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(DB),
    .FIFO_DEPTH(DEPTH), .PARITY_ODD(PODD)
  ) dut (
    .CLK(CLK), .RESET(RESET), .IN_SERIAL_RX(IN_SERIAL_RX),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .IN_READY(IN_READY),
    .OUT_COUNT(OUT_COUNT), .OUT_FRAME_ERR(OUT_FRAME_ERR),
    .OUT_PARITY_ERR(OUT_PARITY_ERR), .OUT_OVERRUN(OUT_OVERRUN)
  );

  always #5 CLK = ~CLK;

  int checks = 0, failures = 0;
  int ferr_cnt = 0, perr_cnt = 0, ovr_cnt = 0;
  int ferr_exp = 0, perr_exp = 0, ovr_exp = 0;
  logic [DB-1:0] q[$];

  always @(negedge CLK) begin
    if (OUT_FRAME_ERR === 1'b1)  ferr_cnt++;
    if (OUT_PARITY_ERR === 1'b1) perr_cnt++;
    if (OUT_OVERRUN === 1'b1)    ovr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic bit_out(input logic v);
    IN_SERIAL_RX = v;
    step(BIT_CYC);
  endtask

  // Start bit, data LSB first, optional parity, stop bit, optional held-low break, then idle.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop_val,
                            input logic par_flip, input int low_bits);
    bit_out(1'b0);
    for (int i = 0; i < DB; i++) bit_out(d[i]);
    if (PAR_EN) bit_out((^d) ^ PODD ^ par_flip);
    bit_out(stop_val);
    repeat (low_bits) bit_out(1'b0);
    IN_SERIAL_RX = 1'b1;
    step(2 * BIT_CYC);
  endtask

  task automatic model_frame(input logic [DB-1:0] d, input logic stop_ok, input logic par_ok);
    if (!stop_ok)                ferr_exp++;
    else if (!par_ok)            perr_exp++;
    else if (q.size() < DEPTH)   q.push_back(d);
    else                         ovr_exp++;
  endtask

  task automatic drain(input int n, input string tag);
    logic [DB-1:0] exp;
    for (int i = 0; i < n; i++) begin
      exp = q.pop_front();
      chk({tag, "_valid"}, OUT_VALID, 1);
      chk({tag, "_data"}, OUT_DATA, exp);
      IN_READY = 1'b1;
      step(1);
      IN_READY = 1'b0;
    end
  endtask

  task automatic chk_errs(input string tag);
    chk({tag, "_ferr"}, ferr_cnt, ferr_exp);
    chk({tag, "_perr"}, perr_cnt, perr_exp);
    chk({tag, "_ovr"},  ovr_cnt,  ovr_exp);
  endtask

  initial begin
    logic [DB-1:0] d, popped_obs;
    logic          ok;
    logic          hit;

    RESET = 1'b1; IN_SERIAL_RX = 1'b1; IN_READY = 1'b0;
    step(5);
    chk("rst_count", OUT_COUNT, 0);
    chk("rst_valid", OUT_VALID, 0);
    chk("rst_data", OUT_DATA, 0);
    chk("rst_pulses", {OUT_FRAME_ERR, OUT_PARITY_ERR, OUT_OVERRUN}, 0);
    RESET = 1'b0;
    step(2 * BIT_CYC);

    // Two clean frames
    send_frame(8'h55, 1'b1, 1'b0, 0); model_frame(8'h55, 1'b1, 1'b1);
    send_frame(8'hA3, 1'b1, 1'b0, 0); model_frame(8'hA3, 1'b1, 1'b1);
    chk("two_count", OUT_COUNT, 2);
    chk_errs("two");
    drain(2, "two");
    chk("two_empty", OUT_VALID, 0);

    // Stop bit low followed by a 3-bit break, then a normal frame
    send_frame(8'h3C, 1'b0, 1'b0, 3); model_frame(8'h3C, 1'b0, 1'b1);
    chk("brk_count", OUT_COUNT, 0);
    chk_errs("brk");
    send_frame(8'h11, 1'b1, 1'b0, 0); model_frame(8'h11, 1'b1, 1'b1);
    chk("brk_next_count", OUT_COUNT, 1);
    drain(1, "brk_next");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 0); model_frame(8'h07, 1'b1, 1'b0);
    chk("par_bad_count", OUT_COUNT, 0);
    chk_errs("par_bad");
    send_frame(8'h07, 1'b1, 1'b0, 0); model_frame(8'h07, 1'b1, 1'b1);
    chk("par_ok_count", OUT_COUNT, 1);
    drain(1, "par_ok");
`endif

    // Random words with occasional framing errors
    for (int i = 0; i < 8; i++) begin
      d  = DB'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      send_frame(d, ok, 1'b0, ok ? 0 : 1);
      model_frame(d, ok, 1'b1);
    end
    chk("rnd_count", OUT_COUNT, q.size());
    chk_errs("rnd");
    drain(q.size(), "rnd");

    // Overrun: 17 words into a 16-deep FIFO with no reads
    for (int i = 0; i < 17; i++) begin
      send_frame(DB'(i), 1'b1, 1'b0, 0);
      model_frame(DB'(i), 1'b1, 1'b1);
    end
    chk("ovr_count", OUT_COUNT, DEPTH);
    chk_errs("ovr");
    drain(DEPTH, "ovr");

    // Full FIFO, pop exactly on the push cycle of a 17th word
    for (int i = 0; i < DEPTH; i++) begin
      send_frame(DB'(8'h40 + i), 1'b1, 1'b0, 0);
      model_frame(DB'(8'h40 + i), 1'b1, 1'b1);
    end
    hit = 1'b0;
    popped_obs = '0;
    fork
      send_frame(8'h5F, 1'b1, 1'b0, 0);
      begin : waiter
        int k;
        k = 0;
        while (!hit && k < 20 * BIT_CYC) begin
          @(posedge CLK);
          #1;
          if (dut.vld_p1 === 1'b1) begin
            popped_obs = OUT_DATA;
            IN_READY = 1'b1;
            hit = 1'b1;
          end
          k++;
        end
        if (hit) begin
          @(posedge CLK);
          #1;
          IN_READY = 1'b0;
        end
      end
    join
    chk("pp_seen", hit, 1);
    chk("pp_popped", popped_obs, q.pop_front());
    q.push_back(8'h5F);
    chk("pp_count", OUT_COUNT, DEPTH);
    chk_errs("pp");
    drain(DEPTH, "pp");

    // One-tick glitch on the idle line
    IN_SERIAL_RX = 1'b0;
    step(DIV);
    IN_SERIAL_RX = 1'b1;
    step(3 * BIT_CYC);
    chk("glitch_count", OUT_COUNT, 0);
    chk_errs("glitch");

    // Reset in the middle of a data bit
    send_frame(8'h21, 1'b1, 1'b0, 0); model_frame(8'h21, 1'b1, 1'b1);
    chk("mid_pre_count", OUT_COUNT, 1);
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b0);
    step(BIT_CYC / 2);
    RESET = 1'b1;
    IN_SERIAL_RX = 1'b1;
    step(1);
    q.delete();
    chk("mid_rst_count", OUT_COUNT, 0);
    chk("mid_rst_valid", OUT_VALID, 0);
    RESET = 1'b0;
    step(3 * BIT_CYC);
    send_frame(8'h5A, 1'b1, 1'b0, 0); model_frame(8'h5A, 1'b1, 1'b1);
    chk("mid_after_count", OUT_COUNT, 1);
    drain(1, "mid_after");
    chk_errs("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
